// File: rtl/jk_bank.sv
// jk_bank: WIDTH-bit JK register bank with up/down counter and parallel load modes; optional toggle counter under JK_BANK_TOGGLE_CNT_EN.
// Latency: q, carry and toggles are registered and update 1 cycle after the sampling edge; qn is combinational from q.
// Backpressure: none; en=0 holds q and toggles and forces carry low.
module jk_bank #(
   parameter int                 WIDTH     = 8,
   parameter logic [WIDTH-1:0]   RESET_VAL = '0,
   parameter int                 CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [WIDTH-1:0]  j,
   input  logic [WIDTH-1:0]  k,
   output logic [WIDTH-1:0]  q,
   output logic [WIDTH-1:0]  qn,
   output logic              carry,
   output logic [CNT_W-1:0]  toggles
);

   typedef enum logic [1:0] {
      MODE_BANK  = 2'b00,
      MODE_UP    = 2'b01,
      MODE_DOWN  = 2'b10,
      MODE_LOAD  = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   mode_e            mode_sel;
   logic [WIDTH-1:0] bank_nxt;
   logic [WIDTH-1:0] up_nxt;
   logic [WIDTH-1:0] down_nxt;
   logic             up_wrap;
   logic             down_wrap;
   logic [WIDTH-1:0] q_nxt;
   logic             carry_nxt;
   logic             q_changes;

   assign mode_sel = mode_e'(mode);

   // Per-bit JK characteristic: set where J and not Q, keep where Q and not K.
   always_comb begin
      bank_nxt = (j & ~q) | (~k & q);
   end

   // Counter candidates and their wrap conditions, evaluated on the current q.
   always_comb begin
      up_nxt    = q + ONE;
      down_nxt  = q - ONE;
      up_wrap   = &q;
      down_wrap = ~|q;
   end

   // Select next state and carry; hold and no carry unless enabled.
   always_comb begin
      q_nxt     = q;
      carry_nxt = 1'b0;
      if (en) begin
         case (mode_sel)
            MODE_BANK: begin
               q_nxt = bank_nxt;
            end
            MODE_UP: begin
               q_nxt     = up_nxt;
               carry_nxt = up_wrap;
            end
            MODE_DOWN: begin
               q_nxt     = down_nxt;
               carry_nxt = down_wrap;
            end
            MODE_LOAD: begin
               q_nxt = j;
            end
            default: begin
               q_nxt     = q;
               carry_nxt = 1'b0;
            end
         endcase
      end
   end

   // An edge counts as a toggle event only when the stored value actually moves.
   always_comb begin
      q_changes = en && (q_nxt != q);
   end

   // State register with synchronous reset overriding enable and mode.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q     <= RESET_VAL;
         carry <= 1'b0;
      end else begin
         q     <= q_nxt;
         carry <= carry_nxt;
      end
   end

   assign qn = ~q;

`ifdef JK_BANK_TOGGLE_CNT_EN
   localparam logic [CNT_W-1:0] TOG_MAX = '1;
   localparam logic [CNT_W-1:0] TOG_ONE = CNT_W'(1);

   logic [CNT_W-1:0] tog_cnt;

   // Saturating count of edges where q changed; cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tog_cnt <= '0;
      end else if (q_changes && (tog_cnt != TOG_MAX)) begin
         tog_cnt <= tog_cnt + TOG_ONE;
      end
   end

   assign toggles = tog_cnt;
`else
   logic unused_changes;
   assign unused_changes = q_changes;
   assign toggles        = '0;
`endif

endmodule

// File: tb/tb_jk_bank.sv
module tb_jk_bank;

   localparam int         W      = 4;
   localparam logic [3:0] RV     = 4'h5;
   localparam int         CW     = 2;
   localparam int         TOGMAX = 3;
`ifdef JK_BANK_TOGGLE_CNT_EN
   localparam bit TOG_ON = 1'b1;
`else
   localparam bit TOG_ON = 1'b0;
`endif

   logic          clk;
   logic          rst_n;
   logic          en;
   logic [1:0]    mode;
   logic [W-1:0]  j;
   logic [W-1:0]  k;
   logic [W-1:0]  q;
   logic [W-1:0]  qn;
   logic          carry;
   logic [CW-1:0] toggles;

   int compared;
   int mismatched;

   // reference model state (plain integers)
   int m_q;
   int m_carry;
   int m_tog;

   jk_bank #(.WIDTH(W), .RESET_VAL(RV), .CNT_W(CW)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .mode    (mode),
      .j       (j),
      .k       (k),
      .q       (q),
      .qn      (qn),
      .carry   (carry),
      .toggles (toggles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural model of one rising edge, from the operating rules
   task automatic model_edge(input int r, input int e, input int md, input int jv, input int kv);
      int nq;
      if (r == 0) begin
         m_q = RV; m_carry = 0; m_tog = 0;
         return;
      end
      if (e == 0) begin
         m_carry = 0;
         return;
      end
      nq = m_q;
      m_carry = 0;
      if (md == 0) begin
         nq = 0;
         for (int i = 0; i < W; i++) begin
            int bq, bj, bk, nb;
            bq = (m_q >> i) & 1; bj = (jv >> i) & 1; bk = (kv >> i) & 1;
            if (bj == 0 && bk == 0) nb = bq;
            else if (bj == 0) nb = 0;
            else if (bk == 0) nb = 1;
            else nb = 1 - bq;
            nq = nq + (nb << i);
         end
      end else if (md == 1) begin
         m_carry = (m_q == 15) ? 1 : 0;
         nq = (m_q + 1) % 16;
      end else if (md == 2) begin
         m_carry = (m_q == 0) ? 1 : 0;
         nq = (m_q + 15) % 16;
      end else begin
         nq = jv;
      end
      if (nq != m_q && m_tog < TOGMAX) m_tog = m_tog + 1;
      m_q = nq;
   endtask

   task automatic check_all(input string tag);
      logic [3:0]    eq, eqn;
      logic          ec;
      logic [CW-1:0] et;
      eq  = 4'(m_q);
      eqn = 4'(15 - m_q);
      ec  = (m_carry != 0);
      et  = TOG_ON ? CW'(m_tog) : '0;
      compared++;
      assert (q === eq) else begin
         mismatched++;
         $error("FAIL %s.q observed=%h expected=%h", tag, q, eq);
      end
      compared++;
      assert (qn === eqn) else begin
         mismatched++;
         $error("FAIL %s.qn observed=%h expected=%h", tag, qn, eqn);
      end
      compared++;
      assert (carry === ec) else begin
         mismatched++;
         $error("FAIL %s.carry observed=%b expected=%b", tag, carry, ec);
      end
      compared++;
      assert (toggles === et) else begin
         mismatched++;
         $error("FAIL %s.toggles observed=%0d expected=%0d", tag, toggles, et);
      end
   endtask

   // drive one edge's inputs at the falling edge, check just after the rising edge
   task automatic step(input string tag, input int r, input int e, input int md, input int jv, input int kv);
      @(negedge clk);
      rst_n = r[0]; en = e[0]; mode = md[1:0]; j = jv[3:0]; k = kv[3:0];
      model_edge(r, e, md, jv, kv);
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic chk_const(input string tag, input logic [3:0] got, input logic [3:0] want);
      compared++;
      assert (got === want) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, got, want);
      end
   endtask

   initial begin
      compared = 0; mismatched = 0;
      m_q = 0; m_carry = 0; m_tog = 0;
      rst_n = 1'b0; en = 1'b0; mode = 2'b00; j = '0; k = '0;

      // reset with en=1 and counting requested
      step("reset", 0, 1, 1, 0, 0);
      chk_const("reset_q_const", q, 4'h5);
      chk_const("reset_qn_const", qn, 4'hA);

      // bank toggle from zero
      step("load0", 1, 1, 3, 0, 0);
      step("tog1", 1, 1, 0, 15, 15);
      chk_const("tog1_const", q, 4'hF);
      step("tog2", 1, 1, 0, 15, 15);
      chk_const("tog2_const", q, 4'h0);
      step("tog3", 1, 1, 0, 15, 15);

      // hold / clear / set / toggle per bit
      step("load_a", 1, 1, 3, 10, 0);
      step("bank_mix", 1, 1, 0, 3, 5);
      chk_const("bank_mix_const", q, 4'hB);

      // load then count up across the wrap, then down across it
      step("load_e", 1, 1, 3, 14, 9);
      step("up1", 1, 1, 1, 0, 0);
      step("up2", 1, 1, 1, 0, 0);
      chk_const("up2_const", q, 4'h0);
      compared++;
      assert (carry === 1'b1) else begin
         mismatched++;
         $error("FAIL up2_carry observed=%b expected=1", carry);
      end
      step("up3", 1, 1, 1, 0, 0);
      step("dn1", 1, 1, 2, 0, 0);
      step("dn2", 1, 1, 2, 0, 0);
      chk_const("dn2_const", q, 4'hF);

      // enable low holds, reset mid-count, resume from reset value
      for (int i = 0; i < 3; i++) step("en_low", 1, 0, 1, 7, 7);
      step("cnt", 1, 1, 1, 0, 0);
      step("mid_rst", 0, 1, 1, 0, 0);
      step("resume1", 1, 1, 1, 0, 0);
      chk_const("resume1_const", q, 4'h6);
      step("resume2", 1, 1, 1, 0, 0);

      // toggle counter saturation and hold edge
      step("sat_rst", 0, 1, 0, 0, 0);
      for (int i = 0; i < 5; i++) step("sat_tog", 1, 1, 0, 15, 15);
      step("sat_hold", 1, 1, 0, 0, 0);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         int r, e, md, jv, kv;
         r  = ($urandom_range(0, 19) == 0) ? 0 : 1;
         e  = ($urandom_range(0, 5) == 0) ? 0 : 1;
         md = $urandom_range(0, 3);
         jv = $urandom_range(0, 15);
         kv = $urandom_range(0, 15);
         step("rand", r, e, md, jv, kv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
